// File: rtl/uart_loader.sv
// Parses framed program images arriving from the UART receiver and writes them as 32-bit words
// into instruction memory, holding the CPU in reset while a load is in progress.
module uart_loader #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_dout,
    input  logic                  rx_done_tick,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  cpu_hold,
    output logic                  load_done_tick,
    output logic                  load_err_tick
);

    localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     MaxLen  = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StData, StCsum} state_e;

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           word_idx_q, word_idx_d;
    logic [7:0]            csum_q, csum_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           shift_q, shift_d;
    logic [TmoW-1:0]       tmo_q, tmo_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [15:0] len_full;
    logic        oversize;
    logic        timeout;
    logic        word_end;
    logic        last_word;

    assign len_full  = {rx_dout, len_q[7:0]};
    assign oversize  = {1'b0, len_full} > MaxLen;
    // A byte arriving in the limit cycle takes priority over the timeout.
    assign timeout   = (state_q != StIdle) && !rx_done_tick && (tmo_q == TmoLast);
    assign word_end  = rx_done_tick && (byte_cnt_q == 2'd3);
    assign last_word = (word_idx_q == len_q - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = StIdle;
        end else if (rx_done_tick) begin
            case (state_q)
                StIdle:  if (rx_dout == SYNC_BYTE) state_d = StLenLo;
                StLenLo: state_d = StLenHi;
                StLenHi: begin
                    if (oversize)             state_d = StIdle;
                    else if (len_full == '0)  state_d = StCsum;
                    else                      state_d = StData;
                end
                StData:  if (word_end && last_word) state_d = StCsum;
                StCsum:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        csum_d      = csum_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        tmo_d       = (state_q == StIdle || rx_done_tick) ? '0 : tmo_q + TmoW'(1);
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = (state_d != StIdle);
        done_d      = 1'b0;
        err_d       = timeout;
        if (rx_done_tick) begin
            case (state_q)
                StIdle: begin
                    if (rx_dout == SYNC_BYTE) begin
                        csum_d     = '0;
                        word_idx_d = '0;
                        byte_cnt_d = '0;
                    end
                end
                StLenLo: begin
                    len_d[7:0] = rx_dout;
                    csum_d     = csum_q ^ rx_dout;
                end
                StLenHi: begin
                    len_d  = len_full;
                    csum_d = csum_q ^ rx_dout;
                    err_d  = oversize;
                end
                StData: begin
                    csum_d     = csum_q ^ rx_dout;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = {rx_dout, shift_q[23:8]};
                    if (word_end) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = {rx_dout, shift_q};
                        word_idx_d  = word_idx_q + 16'd1;
                    end
                end
                StCsum: begin
                    if (rx_dout == csum_q) done_d = 1'b1;
                    else                   err_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q       <= '0;
            word_idx_q  <= '0;
            csum_q      <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            csum_q      <= csum_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign busy           = busy_q;
    assign cpu_hold       = busy_q;
    assign load_done_tick = done_q;
    assign load_err_tick  = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: byte streams are parsed by a queue-based frame model and the observed
// writes and status pulses (with their cycle numbers) are compared against it.
module tb_uart_loader;

    localparam int unsigned AW = 10;
    localparam int unsigned TC = 40;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_dout = '0;
    logic          rx_done_tick = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy, cpu_hold, load_done_tick, load_err_tick;

    uart_loader #(
        .ADDR_WIDTH    (AW),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_dout       (rx_dout),
        .rx_done_tick  (rx_done_tick),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .busy          (busy),
        .cpu_hold      (cpu_hold),
        .load_done_tick(load_done_tick),
        .load_err_tick (load_err_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {logic [31:0] addr; logic [31:0] data; int cyc;} wr_t;
    typedef struct packed {logic ok; int cyc;} st_t;

    wr_t got_wr[$], exp_wr[$];
    st_t got_st[$], exp_st[$];
    logic [7:0] sent_b[$];
    int sent_c[$];

    // Every visible write or status pulse is logged, including any during reset.
    always @(negedge clk) begin
        if (mem_we) got_wr.push_back('{addr: 32'(mem_addr), data: mem_wdata, cyc: cyc});
        if (load_done_tick) got_st.push_back('{ok: 1'b1, cyc: cyc});
        if (load_err_tick) got_st.push_back('{ok: 1'b0, cyc: cyc});
    end

    task automatic send_byte(input logic [7:0] b);
        rx_dout = b;
        rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        sent_b.push_back(b);
        sent_c.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        got_wr.delete(); got_st.delete(); sent_b.delete(); sent_c.delete();
        exp_wr.delete(); exp_st.delete();
    endtask

    // Frame-level parse of everything sent: expected writes and status pulses with their cycles.
    task automatic model();
        int i;
        logic [15:0] len;
        logic [7:0] x;
        logic [31:0] word;
        bit stop;
        i = 0;
        stop = 0;
        exp_wr.delete();
        exp_st.delete();
        while (!stop && i < sent_b.size()) begin
            if (sent_b[i] != 8'hA5) begin i++; continue; end
            if (i + 2 >= sent_b.size()) break;
            len = {sent_b[i+2], sent_b[i+1]};
            x = sent_b[i+1] ^ sent_b[i+2];
            i += 3;
            if (int'(len) > (1 << AW)) begin
                exp_st.push_back('{ok: 1'b0, cyc: sent_c[i-1]});
                continue;
            end
            for (int w = 0; w < int'(len); w++) begin
                if (i + 3 >= sent_b.size()) begin stop = 1; break; end
                word = {sent_b[i+3], sent_b[i+2], sent_b[i+1], sent_b[i]};
                x = x ^ sent_b[i] ^ sent_b[i+1] ^ sent_b[i+2] ^ sent_b[i+3];
                exp_wr.push_back('{addr: 32'(w), data: word, cyc: sent_c[i+3]});
                i += 4;
            end
            if (stop || i >= sent_b.size()) break;
            exp_st.push_back('{ok: (sent_b[i] == x), cyc: sent_c[i]});
            i++;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({mem_we, mem_addr, mem_wdata, busy, cpu_hold, load_done_tick, load_err_tick} !== '0)
        begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%b addr=%0h wdata=%h busy=%b hold=%b done=%b err=%b expected all 0",
                     mem_we, mem_addr, mem_wdata, busy, cpu_hold, load_done_tick, load_err_tick);
        end
    endtask

    task automatic test_good_load();
        logic [7:0] f[12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00,
                              8'h10, 8'h00, 8'h92};
        clear_q();
        foreach (f[k]) begin
            send_byte(f[k]);
            n_checks++;
            if ({busy, cpu_hold} !== ((k < 11) ? 2'b11 : 2'b00)) begin
                n_fail++;
                $display("FAIL good_busy[%0d]: got busy=%b hold=%b expected %b", k, busy, cpu_hold,
                         (k < 11));
            end
        end
        idle(3);
        model();
        n_checks++;
        if (got_wr.size() != 2 || got_wr[0].data !== 32'h13 || got_wr[1].data !== 32'h00100093
            || got_wr[1].addr !== 32'd1) begin
            n_fail++;
            $display("FAIL good_words: got %0d writes expected (0,00000013) (1,00100093)",
                     got_wr.size());
        end
        n_checks++;
        if (got_wr.size() != exp_wr.size() || got_st.size() != exp_st.size()) begin
            n_fail++;
            $display("FAIL good_counts: got wr=%0d st=%0d expected wr=%0d st=%0d", got_wr.size(),
                     got_st.size(), exp_wr.size(), exp_st.size());
        end
        foreach (exp_wr[k]) if (k < got_wr.size()) begin
            n_checks++;
            if (got_wr[k] !== exp_wr[k]) begin
                n_fail++;
                $display("FAIL good_wr[%0d]: got a=%0h d=%h c=%0d expected a=%0h d=%h c=%0d", k,
                         got_wr[k].addr, got_wr[k].data, got_wr[k].cyc, exp_wr[k].addr,
                         exp_wr[k].data, exp_wr[k].cyc);
            end
        end
        foreach (exp_st[k]) if (k < got_st.size()) begin
            n_checks++;
            if (got_st[k] !== exp_st[k] || !exp_st[k].ok) begin
                n_fail++;
                $display("FAIL good_status[%0d]: got ok=%b c=%0d expected ok=1 c=%0d", k,
                         got_st[k].ok, got_st[k].cyc, exp_st[k].cyc);
            end
        end
    endtask

    task automatic test_bad_csum_and_oversize();
        logic [7:0] f[15] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00,
                              8'h10, 8'h00, 8'h93, 8'hA5, 8'h01, 8'h04};
        clear_q();
        foreach (f[k]) send_byte(f[k]);
        idle(3);
        model();
        n_checks++;
        if (got_wr.size() != exp_wr.size() || got_st.size() != 2 || exp_st.size() != 2) begin
            n_fail++;
            $display("FAIL bad_counts: got wr=%0d st=%0d expected wr=%0d st=2", got_wr.size(),
                     got_st.size(), exp_wr.size());
        end
        foreach (exp_wr[k]) if (k < got_wr.size()) begin
            n_checks++;
            if (got_wr[k] !== exp_wr[k]) begin
                n_fail++;
                $display("FAIL bad_wr[%0d]: got a=%0h d=%h c=%0d expected a=%0h d=%h c=%0d", k,
                         got_wr[k].addr, got_wr[k].data, got_wr[k].cyc, exp_wr[k].addr,
                         exp_wr[k].data, exp_wr[k].cyc);
            end
        end
        foreach (exp_st[k]) if (k < got_st.size()) begin
            n_checks++;
            if (got_st[k] !== exp_st[k] || exp_st[k].ok) begin
                n_fail++;
                $display("FAIL bad_status[%0d]: got ok=%b c=%0d expected ok=0 c=%0d", k,
                         got_st[k].ok, got_st[k].cyc, exp_st[k].cyc);
            end
        end
    endtask

    task automatic test_garbage_zero_len();
        logic [7:0] g[3] = '{8'h00, 8'hFF, 8'h5A};
        clear_q();
        foreach (g[k]) begin
            send_byte(g[k]);
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL garbage_busy[%0d]: got %b expected 0", k, busy);
            end
        end
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        idle(3);
        n_checks++;
        if (got_wr.size() != 0 || got_st.size() != 1 || got_st[0] !== '{ok: 1'b1, cyc: sent_c[6]})
        begin
            n_fail++;
            $display("FAIL zero_len: got wr=%0d st=%0d expected wr=0 one done at cyc %0d",
                     got_wr.size(), got_st.size(), sent_c[6]);
        end
    endtask

    task automatic test_timeout();
        int t;
        clear_q();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h13);
        t = sent_c[3];
        idle(TC - 1);
        n_checks++;
        if (busy !== 1'b1 || got_st.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_early: got busy=%b st=%0d expected busy=1 st=0", busy,
                     got_st.size());
        end
        idle(4);
        n_checks++;
        if (got_st.size() != 1 || got_st[0] !== '{ok: 1'b0, cyc: t + TC} || busy !== 1'b0
            || got_wr.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_err: got st=%0d first_cyc=%0d busy=%b wr=%0d expected err at %0d",
                     got_st.size(), (got_st.size() > 0) ? got_st[0].cyc : -1, busy, got_wr.size(),
                     t + TC);
        end
        clear_q();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        idle(3);
        n_checks++;
        if (got_st.size() != 1 || got_st[0] !== '{ok: 1'b1, cyc: sent_c[3]}) begin
            n_fail++;
            $display("FAIL timeout_recover: got st=%0d expected one done at cyc %0d",
                     got_st.size(), sent_c[3]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] f[12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00,
                              8'h10, 8'h00, 8'h92};
        clear_q();
        for (int k = 0; k < 5; k++) send_byte(f[k]);
        reset = 1'b1;
        idle(1);
        test_reset();
        reset = 1'b0;
        idle(2);
        n_checks++;
        if (got_wr.size() != 0 || got_st.size() != 0) begin
            n_fail++;
            $display("FAIL reset_spurious: got wr=%0d st=%0d expected 0 0", got_wr.size(),
                     got_st.size());
        end
        clear_q();
        foreach (f[k]) send_byte(f[k]);
        idle(3);
        model();
        n_checks++;
        if (got_wr.size() != 2 || got_wr[0] !== exp_wr[0] || got_wr[1] !== exp_wr[1]
            || got_st.size() != 1 || got_st[0] !== exp_st[0]) begin
            n_fail++;
            $display("FAIL reset_reload: got wr=%0d st=%0d expected wr=2 st=1 matching model",
                     got_wr.size(), got_st.size());
        end
    endtask

    task automatic test_max_len();
        logic [7:0] x;
        logic [7:0] b;
        clear_q();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
        x = 8'h04;
        for (int k = 0; k < 4 * (1 << AW); k++) begin
            b = 8'($urandom);
            x ^= b;
            send_byte(b);
        end
        send_byte(x);
        idle(3);
        model();
        n_checks++;
        if (got_wr.size() != (1 << AW) || got_wr.size() != exp_wr.size()) begin
            n_fail++;
            $display("FAIL max_len_count: got %0d writes expected %0d", got_wr.size(), 1 << AW);
        end
        else begin
            foreach (exp_wr[k]) begin
                n_checks++;
                if (got_wr[k] !== exp_wr[k]) begin
                    n_fail++;
                    $display("FAIL max_len_wr[%0d]: got a=%0h d=%h expected a=%0h d=%h", k,
                             got_wr[k].addr, got_wr[k].data, exp_wr[k].addr, exp_wr[k].data);
                end
            end
        end
        n_checks++;
        if (got_st.size() != 1 || got_st[0] !== '{ok: 1'b1, cyc: sent_c[sent_c.size()-1]}) begin
            n_fail++;
            $display("FAIL max_len_done: got st=%0d expected one done", got_st.size());
        end
    endtask

    task automatic test_random_back_to_back();
        int len, kind;
        logic [7:0] x, b;
        clear_q();
        for (int f = 0; f < 40; f++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                b = 8'($urandom_range(0, 254));
                send_byte((b == 8'hA5) ? 8'h00 : b);
            end
            kind = $urandom_range(0, 7);
            len = (kind == 0) ? (1 << AW) + 1 + $urandom_range(0, 3000) : $urandom_range(0, 4);
            send_byte(8'hA5);
            send_byte(8'(len));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_byte(8'(len >> 8));
            x = 8'(len) ^ 8'(len >> 8);
            if (kind == 0) continue;
            for (int k = 0; k < 4 * len; k++) begin
                b = 8'($urandom);
                x ^= b;
                send_byte(b);
                if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
            end
            send_byte((kind == 1) ? x ^ 8'($urandom_range(1, 255)) : x);
        end
        idle(3);
        model();
        n_checks++;
        if (got_wr.size() != exp_wr.size() || got_st.size() != exp_st.size()) begin
            n_fail++;
            $display("FAIL rand_counts: got wr=%0d st=%0d expected wr=%0d st=%0d", got_wr.size(),
                     got_st.size(), exp_wr.size(), exp_st.size());
        end
        foreach (exp_wr[k]) if (k < got_wr.size()) begin
            n_checks++;
            if (got_wr[k] !== exp_wr[k]) begin
                n_fail++;
                $display("FAIL rand_wr[%0d]: got a=%0h d=%h c=%0d expected a=%0h d=%h c=%0d", k,
                         got_wr[k].addr, got_wr[k].data, got_wr[k].cyc, exp_wr[k].addr,
                         exp_wr[k].data, exp_wr[k].cyc);
            end
        end
        foreach (exp_st[k]) if (k < got_st.size()) begin
            n_checks++;
            if (got_st[k] !== exp_st[k]) begin
                n_fail++;
                $display("FAIL rand_status[%0d]: got ok=%b c=%0d expected ok=%b c=%0d", k,
                         got_st[k].ok, got_st[k].cyc, exp_st[k].ok, exp_st[k].cyc);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        idle(2);
        test_good_load();
        test_bad_csum_and_oversize();
        test_garbage_zero_len();
        test_timeout();
        test_reset_mid_frame();
        test_max_len();
        test_random_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
